// File: rtl/img_tile_reader.sv
// Tile sequencer in front of the image ROM: walks a tile in raster order, zero-pads out-of-bounds
// pixels and streams them through a small credit-controlled FIFO with valid/ready backpressure.
module img_tile_reader #(
    parameter int IMG_W = 224,
    parameter int IMG_H = 224,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [9:0]   cfg_x0,
    input  logic signed [9:0]   cfg_y0,
    input  logic [7:0]          cfg_tw,
    input  logic [7:0]          cfg_th,
    output logic                busy,
    output logic                done,
    output logic                rom_en,
    output logic [AW-1:0]       rom_addr,
    input  logic [23:0]         rom_dout,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [23:0]         m_data,
    output logic                m_last,
    output logic                m_pad
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t          state_r, state_nxt_s;
    logic [9:0]      x0_r, y0_r;
    logic [7:0]      tw_r, th_r, c_r, r_r;
    logic [AW-1:0]   addr_hold_r, addr_s;
    logic [10:0]     x_s, y_s;
    logic            inb_s, last_s, credit_ok_s, issue_s, accept_s;
    logic            s2_vld_r, s2_pad_r, s2_last_r;
    logic            busy_r, busy_nxt_s, done_r, done_nxt_s;
    logic [23:0]     fifo_data_r [4];
    logic            fifo_pad_r  [4];
    logic            fifo_last_r [4];
    logic [23:0]     fifo_data_nxt_s [4];
    logic            fifo_pad_nxt_s  [4];
    logic            fifo_last_nxt_s [4];
    logic [2:0]      count_r, count_nxt_s, wr_idx_s;
    logic            m_valid_r, push_s, pop_s;
    logic [23:0]     push_data_s;

    // Pixel coordinates, bounds test, address and issue credit for the current slot
    always_comb begin
        x_s         = {x0_r[9], x0_r} + {3'b000, c_r};
        y_s         = {y0_r[9], y0_r} + {3'b000, r_r};
        inb_s       = !x_s[10] && (x_s < 11'(IMG_W)) && !y_s[10] && (y_s < 11'(IMG_H));
        addr_s      = AW'(y_s) * AW'(IMG_W) + AW'(x_s);
        last_s      = (c_r == tw_r - 8'd1) && (r_r == th_r - 8'd1);
        // in-flight = FIFO entries plus the slot waiting on ROM data
        credit_ok_s = (count_r + {2'b00, s2_vld_r}) < 3'd3;
        issue_s     = (state_r == RUN) && credit_ok_s;
        accept_s    = (state_r == IDLE) && start;
    end

    assign rom_en   = issue_s && inb_s;
    assign rom_addr = rom_en ? addr_s : addr_hold_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state, busy and done decisions
    always_comb begin
        state_nxt_s = state_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if ((cfg_tw == 8'd0) || (cfg_th == 8'd0)) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                        busy_nxt_s  = 1'b1;
                    end
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            RUN: begin
                if (issue_s && last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (pop_s && m_last) begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Command latch, raster counters, address hold and ROM-stage tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_r        <= 10'd0;
            y0_r        <= 10'd0;
            tw_r        <= 8'd0;
            th_r        <= 8'd0;
            c_r         <= 8'd0;
            r_r         <= 8'd0;
            addr_hold_r <= '0;
            s2_vld_r    <= 1'b0;
            s2_pad_r    <= 1'b0;
            s2_last_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            s2_vld_r  <= issue_s;
            s2_pad_r  <= issue_s && !inb_s;
            s2_last_r <= issue_s && last_s;
            if (rom_en) begin
                addr_hold_r <= addr_s;
            end
            if (accept_s) begin
                x0_r <= cfg_x0;
                y0_r <= cfg_y0;
                tw_r <= cfg_tw;
                th_r <= cfg_th;
                c_r  <= 8'd0;
                r_r  <= 8'd0;
            end else if (issue_s) begin
                if (c_r == tw_r - 8'd1) begin
                    c_r <= 8'd0;
                    r_r <= r_r + 8'd1;
                end else begin
                    c_r <= c_r + 8'd1;
                end
            end
        end
    end

    // Shift-register FIFO next state: entry 0 is always the stream head
    always_comb begin
        push_s          = s2_vld_r;
        pop_s           = m_valid_r && m_ready;
        push_data_s     = s2_pad_r ? 24'h000000 : rom_dout;
        wr_idx_s        = pop_s ? (count_r - 3'd1) : count_r;
        count_nxt_s     = count_r + {2'b00, push_s} - {2'b00, pop_s};
        fifo_data_nxt_s = fifo_data_r;
        fifo_pad_nxt_s  = fifo_pad_r;
        fifo_last_nxt_s = fifo_last_r;
        if (pop_s) begin
            for (int i = 0; i < 3; i++) begin
                fifo_data_nxt_s[i] = fifo_data_r[i+1];
                fifo_pad_nxt_s[i]  = fifo_pad_r[i+1];
                fifo_last_nxt_s[i] = fifo_last_r[i+1];
            end
        end else begin
            fifo_data_nxt_s = fifo_data_r;
        end
        for (int i = 0; i < 4; i++) begin
            if (push_s && (wr_idx_s == 3'(i))) begin
                fifo_data_nxt_s[i] = push_data_s;
                fifo_pad_nxt_s[i]  = s2_pad_r;
                fifo_last_nxt_s[i] = s2_last_r;
            end else begin
                fifo_pad_nxt_s[i] = fifo_pad_nxt_s[i];
            end
        end
    end

    // FIFO storage, occupancy and registered valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_r[i] <= 24'h000000;
                fifo_pad_r[i]  <= 1'b0;
                fifo_last_r[i] <= 1'b0;
            end
            count_r   <= 3'd0;
            m_valid_r <= 1'b0;
        end else begin
            fifo_data_r <= fifo_data_nxt_s;
            fifo_pad_r  <= fifo_pad_nxt_s;
            fifo_last_r <= fifo_last_nxt_s;
            count_r     <= count_nxt_s;
            m_valid_r   <= (count_nxt_s != 3'd0);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign m_valid = m_valid_r;
    assign m_data  = fifo_data_r[0];
    assign m_pad   = fifo_pad_r[0];
    assign m_last  = fifo_last_r[0];

endmodule

// File: tb/tb_img_tile_reader.sv
// Directed table-driven bench for img_tile_reader on an 8x8 image with a behavioural 1-cycle ROM.
module tb_img_tile_reader;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst_n, start, m_ready;
    logic signed [9:0] cfg_x0, cfg_y0;
    logic [7:0] cfg_tw, cfg_th;
    logic busy, done, rom_en, m_valid, m_last, m_pad;
    logic [AW-1:0] rom_addr;
    logic [23:0] rom_dout, m_data;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic signed [9:0] x0;
        logic signed [9:0] y0;
        logic [7:0] tw;
        logic [7:0] th;
        int rdy_pct;
        int poke;
        int exp_beats;
        int exp_pads;
        int exp_done;
    } vec_t;

    vec_t vecs[9];
    logic [23:0] cap_data[$];
    logic        cap_pad[$];

    img_tile_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_tw(cfg_tw), .cfg_th(cfg_th),
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_dout(rom_dout), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .m_pad(m_pad)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int a);
        pix = {8'(a), 8'(a * 3 + 1), 8'(a ^ 32'h5A)};
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_dout <= pix(int'(rom_addr));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, t, done_t, first_v, nbeat, nrom, npad, max_cnt, done_cnt;
        int data_err, pad_err, last_err, stall_err, busy_err, rom_err;
        logic [23:0] e_data[$];
        logic        e_pad[$];
        int          e_rom[$];
        logic [23:0] prev_d;
        logic        prev_p, prev_l, prev_stall;
        logic        exp_busy;
        n = int'(v.tw) * int'(v.th);
        for (int k = 0; k < n; k++) begin
            int x, y;
            x = int'(v.x0) + (k % int'(v.tw));
            y = int'(v.y0) + (k / int'(v.tw));
            if (x >= 0 && x < IMG_W && y >= 0 && y < IMG_H) begin
                e_data.push_back(pix(y * IMG_W + x));
                e_pad.push_back(1'b0);
                e_rom.push_back(y * IMG_W + x);
            end else begin
                e_data.push_back(24'h000000);
                e_pad.push_back(1'b1);
            end
        end
        cap_data.delete();
        cap_pad.delete();
        done_t = -1; first_v = -1; nbeat = 0; nrom = 0; npad = 0; max_cnt = 0; done_cnt = 0;
        data_err = 0; pad_err = 0; last_err = 0; stall_err = 0; busy_err = 0; rom_err = 0;
        prev_stall = 1'b0; prev_d = 24'h0; prev_p = 1'b0; prev_l = 1'b0;
        @(negedge clk);
        cfg_x0 = v.x0; cfg_y0 = v.y0; cfg_tw = v.tw; cfg_th = v.th;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        while (1) begin
            @(negedge clk);
            t++;
            if (v.poke != 0 && t == 5) begin
                cfg_x0 = 10'sd0; cfg_y0 = 10'sd0; cfg_tw = 8'd3; cfg_th = 8'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            m_ready = (int'($urandom_range(0, 99)) < v.rdy_pct);
            if (prev_stall && (!m_valid || m_data != prev_d || m_pad != prev_p || m_last != prev_l))
                stall_err++;
            if (m_valid && first_v < 0) first_v = t;
            if (rom_en) begin
                if (nrom >= e_rom.size() || int'(rom_addr) != e_rom[nrom]) rom_err++;
                nrom++;
            end
            if (int'(dut.count_r) > max_cnt) max_cnt = int'(dut.count_r);
            if (done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            exp_busy = (done_t < 0) && (n != 0);
            if (busy != exp_busy) busy_err++;
            if (m_valid && m_ready) begin
                cap_data.push_back(m_data);
                cap_pad.push_back(m_pad);
                if (nbeat >= n) data_err++;
                else begin
                    if (m_data != e_data[nbeat]) data_err++;
                    if (m_pad != e_pad[nbeat]) pad_err++;
                    if (m_last != (nbeat == n - 1)) last_err++;
                end
                if (m_pad) npad++;
                nbeat++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data; prev_p = m_pad; prev_l = m_last;
            if (done_t >= 0 && t >= done_t + 2) break;
            if (t > 3000) break;
        end
        m_ready = 1'b0;
        chk({tag, " done_seen"}, int'(done_t >= 0), 1);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " beats"}, nbeat, v.exp_beats);
        chk({tag, " pads"}, npad, v.exp_pads);
        chk({tag, " data_errs"}, data_err, 0);
        chk({tag, " pad_errs"}, pad_err, 0);
        chk({tag, " last_errs"}, last_err, 0);
        chk({tag, " rom_reads"}, nrom, v.exp_beats - v.exp_pads);
        chk({tag, " rom_addr_errs"}, rom_err, 0);
        chk({tag, " busy_errs"}, busy_err, 0);
        chk({tag, " stall_errs"}, stall_err, 0);
        chk({tag, " fifo_max_le3"}, int'(max_cnt <= 3), 1);
        if (v.exp_beats > 0) chk({tag, " first_valid"}, first_v, 3);
        else chk({tag, " no_valid"}, first_v, -1);
        if (v.exp_done >= 0) chk({tag, " done_cycle"}, done_t, v.exp_done);
    endtask

    initial begin
        int nb, guard, dn;
        //            x0      y0      tw     th    rdy  poke beats pads done
        vecs[0] = '{10'sd0,  10'sd0,  8'd8, 8'd8, 100, 0,  64,  0,  67};
        vecs[1] = '{-10'sd1, -10'sd1, 8'd3, 8'd3, 100, 0,   9,  5,  12};
        vecs[2] = '{10'sd5,  10'sd6,  8'd4, 8'd3, 100, 0,  12,  6,  15};
        vecs[3] = '{10'sd5,  10'sd6,  8'd4, 8'd3,  30, 0,  12,  6,  -1};
        vecs[4] = '{10'sd0,  10'sd0,  8'd0, 8'd5, 100, 0,   0,  0,   1};
        vecs[5] = '{10'sd6,  10'sd6,  8'd4, 8'd4, 100, 0,  16, 12,  19};
        vecs[6] = '{10'sd7,  10'sd7,  8'd1, 8'd1, 100, 0,   1,  0,   4};
        vecs[7] = '{10'sd2,  10'sd1,  8'd5, 8'd4, 100, 1,  20,  0,  23};
        vecs[8] = '{-10'sd3, 10'sd2,  8'd2, 8'd2, 100, 0,   4,  4,   7};

        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
        cfg_x0 = 10'sd0; cfg_y0 = 10'sd0; cfg_tw = 8'd0; cfg_th = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", int'({busy, done, rom_en, m_valid, m_last, m_pad}), 0);
        chk("reset_addr", int'(rom_addr), 0);
        chk("reset_data", int'(m_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) begin
                chk("corner_b0_pad", int'({cap_pad[0], cap_pad[1], cap_pad[2], cap_pad[3], cap_pad[6]}), 31);
                chk("corner_b4", int'(cap_data[4]), int'(pix(0)));
                chk("corner_b5", int'(cap_data[5]), int'(pix(1)));
                chk("corner_b7", int'(cap_data[7]), int'(pix(8)));
                chk("corner_b8", int'(cap_data[8]), int'(pix(9)));
            end
        end

        // Abort a 64-beat tile after 10 beats with an asynchronous reset
        @(negedge clk);
        cfg_x0 = 10'sd0; cfg_y0 = 10'sd0; cfg_tw = 8'd8; cfg_th = 8'd8;
        start = 1'b1; m_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0; guard = 0;
        while (nb < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (m_valid && m_ready) nb++;
        end
        chk("abort_pre_beats", nb, 10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", int'({busy, done, rom_en, m_valid, m_last, m_pad}), 0);
        chk("abort_addr", int'(rom_addr), 0);
        chk("abort_data", int'(m_data), 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || m_valid) dn++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || m_valid || busy) dn++;
        end
        chk("abort_quiet", dn, 0);
        m_ready = 1'b0;
        run_vec(vecs[0], "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
